// File: rtl/sips4_input_cond_if.sv
// sips4_input_cond_if: IN-port read bus between the SIPS4 core and the input
// conditioner. The core (master) selects a port and strobes rd_en; the
// conditioner (slave) returns the selected port combinationally on rd_data.
interface sips4_input_cond_if;
    logic       rd_en;
    logic       rd_port;
    logic [3:0] rd_data;

    modport master (output rd_en, output rd_port, input rd_data);
    modport slave  (input rd_en, input rd_port, output rd_data);
endinterface

// File: rtl/sips4_input_cond.sv
// sips4_input_cond: conditions the board's raw slide switches and push-buttons
// for the SIPS4 core. Every raw bit is synchronized through SYNC_STAGES flops.
// Buttons are then debounced (the level flips only after DB_LIMIT consecutive
// differing samples) and rising levels set sticky press latches, which a
// port-1 read clears. A set on the same edge as a clear wins, so a press is
// never lost.
// Optional feature: define SIPS4_SLIDE_DEBOUNCE_EN to also debounce the four
// slide switches with the same DB_LIMIT (no press latches for slides).
module sips4_input_cond #(
    parameter int SYNC_STAGES    = 2,
    parameter int DB_LIMIT       = 1000000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               slide_raw,
    input  logic [1:0]               button_raw,
    sips4_input_cond_if.slave        bus,
    output logic [1:0]               level,
    output logic [1:0]               press
);

    localparam int                 CNT_W    = $clog2(DB_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DB_LIMIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    // Pin level of a released button; the sync flops reset to it so that
    // leaving reset does not look like a press.
    localparam logic [1:0]         BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    // One debouncer step: returns {next_level, next_count}. The count runs
    // while the synchronized bit disagrees with the level; reaching the limit
    // flips the level and restarts the count on the same edge.
    function automatic logic [CNT_W:0] db_next(
        input logic             sync_bit,
        input logic             lvl,
        input logic [CNT_W-1:0] cnt
    );
        if (sync_bit == lvl) begin
            return {lvl, {CNT_W{1'b0}}};
        end else if (cnt == CNT_MAX) begin
            return {~lvl, {CNT_W{1'b0}}};
        end else begin
            return {lvl, cnt + CNT_ONE};
        end
    endfunction

    logic [SYNC_STAGES-1:0][3:0]  slide_sync_q, slide_sync_d;
    logic [SYNC_STAGES-1:0][1:0]  btn_sync_q,   btn_sync_d;
    logic [1:0]                   btn_pressed;
    logic [1:0][CNT_W-1:0]        btn_cnt_q,    btn_cnt_d;
    logic [1:0]                   level_q,      level_d;
    logic [1:0]                   press_q,      press_d;
    logic [3:0]                   slide_val;

    // Synchronizer shift chains: stage 0 samples the pins, last stage is used.
    always_comb begin
        slide_sync_d    = slide_sync_q;
        btn_sync_d      = btn_sync_q;
        slide_sync_d[0] = slide_raw;
        btn_sync_d[0]   = button_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            slide_sync_d[s] = slide_sync_q[s-1];
            btn_sync_d[s]   = btn_sync_q[s-1];
        end
    end

    // Normalize buttons to 1 = pressed after the last sync stage.
    assign btn_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_sync_q[SYNC_STAGES-1]
                                               :  btn_sync_q[SYNC_STAGES-1];

    // Button debouncers and press latches; a press set overrides a read clear.
    always_comb begin
        btn_cnt_d = btn_cnt_q;
        level_d   = level_q;
        for (int i = 0; i < 2; i++) begin
            {level_d[i], btn_cnt_d[i]} = db_next(btn_pressed[i], level_q[i], btn_cnt_q[i]);
        end
        press_d = press_q;
        if (bus.rd_en && bus.rd_port) begin
            press_d = 2'b00;
        end
        press_d = press_d | (level_d & ~level_q);
    end

    // Synchronizer, button debounce and press-latch state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slide_sync_q <= '0;
            btn_sync_q   <= {SYNC_STAGES{BTN_IDLE}};
            btn_cnt_q    <= '0;
            level_q      <= '0;
            press_q      <= '0;
        end else begin
            slide_sync_q <= slide_sync_d;
            btn_sync_q   <= btn_sync_d;
            btn_cnt_q    <= btn_cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
        end
    end

`ifdef SIPS4_SLIDE_DEBOUNCE_EN
    logic [3:0][CNT_W-1:0] slide_cnt_q,   slide_cnt_d;
    logic [3:0]            slide_level_q, slide_level_d;

    // Slide debouncers: same rule as the buttons, without press latches.
    always_comb begin
        slide_cnt_d   = slide_cnt_q;
        slide_level_d = slide_level_q;
        for (int i = 0; i < 4; i++) begin
            {slide_level_d[i], slide_cnt_d[i]} =
                db_next(slide_sync_q[SYNC_STAGES-1][i], slide_level_q[i], slide_cnt_q[i]);
        end
    end

    // Slide debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slide_cnt_q   <= '0;
            slide_level_q <= '0;
        end else begin
            slide_cnt_q   <= slide_cnt_d;
            slide_level_q <= slide_level_d;
        end
    end

    assign slide_val = slide_level_q;
`else
    assign slide_val = slide_sync_q[SYNC_STAGES-1];
`endif

    // Read port is combinational from registered state so the core can sample
    // it in the same cycle it addresses it.
    assign bus.rd_data = bus.rd_port ? {press_q, level_q} : slide_val;
    assign level       = level_q;
    assign press       = press_q;

endmodule

// File: tb/tb_sips4_input_cond.sv
// tb_sips4_input_cond: scoreboard bench for sips4_input_cond with
// DB_LIMIT=4, SYNC_STAGES=2, active-low buttons. The stimulus process advances
// a behavioural model each clock and queues the expected outputs; a monitor
// pops and compares them on the falling edge.
module tb_sips4_input_cond;

    localparam int SYNC_STAGES    = 2;
    localparam int DB_LIMIT       = 4;
    localparam int BTN_ACTIVE_LOW = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] slide_raw;
    logic [1:0] button_raw;
    logic [1:0] level;
    logic [1:0] press;

    sips4_input_cond_if bus ();

    sips4_input_cond #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DB_LIMIT       (DB_LIMIT),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .slide_raw  (slide_raw),
        .button_raw (button_raw),
        .bus        (bus),
        .level      (level),
        .press      (press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] rd;
        logic [1:0] lvl;
        logic [1:0] prs;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model: raw history per sync stage, run lengths of disagreement.
    logic [3:0] m_sl_pipe [SYNC_STAGES];
    logic [1:0] m_bt_pipe [SYNC_STAGES];
    int         m_run_b   [2];
    int         m_run_s   [4];
    logic [1:0] m_level;
    logic [1:0] m_press;
    logic [3:0] m_sl_level;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SYNC_STAGES; s++) begin
            m_sl_pipe[s] = 4'b0000;
            m_bt_pipe[s] = 2'b11;
        end
        for (int i = 0; i < 2; i++) m_run_b[i] = 0;
        for (int i = 0; i < 4; i++) m_run_s[i] = 0;
        m_level    = 2'b00;
        m_press    = 2'b00;
        m_sl_level = 4'b0000;
    endtask

    // Advance the model by one rising edge using the inputs held before it.
    task automatic model_edge();
        logic [1:0] pressed_now;
        logic [1:0] rise;
        logic [3:0] sl_now;
        if (rst) begin
            model_reset();
            return;
        end
        pressed_now = ~m_bt_pipe[SYNC_STAGES-1];
        sl_now      = m_sl_pipe[SYNC_STAGES-1];
        rise        = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (pressed_now[i] != m_level[i]) begin
                m_run_b[i]++;
                if (m_run_b[i] == DB_LIMIT) begin
                    m_level[i] = ~m_level[i];
                    m_run_b[i] = 0;
                    if (m_level[i]) rise[i] = 1'b1;
                end
            end else begin
                m_run_b[i] = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (sl_now[i] != m_sl_level[i]) begin
                m_run_s[i]++;
                if (m_run_s[i] == DB_LIMIT) begin
                    m_sl_level[i] = ~m_sl_level[i];
                    m_run_s[i]    = 0;
                end
            end else begin
                m_run_s[i] = 0;
            end
        end
        if (bus.rd_en && bus.rd_port) m_press = 2'b00;
        m_press = m_press | rise;
        for (int s = SYNC_STAGES - 1; s > 0; s--) begin
            m_sl_pipe[s] = m_sl_pipe[s-1];
            m_bt_pipe[s] = m_bt_pipe[s-1];
        end
        m_sl_pipe[0] = slide_raw;
        m_bt_pipe[0] = button_raw;
    endtask

    function automatic logic [3:0] slide_view();
`ifdef SIPS4_SLIDE_DEBOUNCE_EN
        return m_sl_level;
`else
        return m_sl_pipe[SYNC_STAGES-1];
`endif
    endfunction

    task automatic push_exp();
        exp_t e;
        e.rd  = bus.rd_port ? {m_press, m_level} : slide_view();
        e.lvl = m_level;
        e.prs = m_press;
        sb_q.push_back(e);
    endtask

    // One clock: model the edge, then drive the next cycle's inputs.
    task automatic cycle(input logic [3:0] sl, input logic [1:0] bt,
                         input logic re, input logic rp, input logic r);
        @(posedge clk);
        model_edge();
        #1;
        slide_raw   = sl;
        button_raw  = bt;
        bus.rd_en   = re;
        bus.rd_port = rp;
        rst         = r;
        if (r) model_reset();
        push_exp();
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rd_data", bus.rd_data, e.rd);
                check("level", 4'(level), 4'(e.lvl));
                check("press", 4'(press), 4'(e.prs));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sl;
        logic [1:0] bt;
        logic       r;
        slide_raw   = 4'b0000;
        button_raw  = 2'b11;
        bus.rd_en   = 1'b0;
        bus.rd_port = 1'b0;
        rst         = 1'b0;

        // Asynchronous reset between edges, checked before the first edge.
        #2 rst = 1'b1;
        #1;
        check("reset_level", 4'(level), 4'b0000);
        check("reset_press", 4'(press), 4'b0000);
        check("reset_rd_p0", bus.rd_data, 4'b0000);
        bus.rd_port = 1'b1;
        #1;
        check("reset_rd_p1", bus.rd_data, 4'b0000);
        model_reset();

        cycle(4'b0000, 2'b11, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0);

        // Clean press on button 0 with slides 1010.
        cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(4'b1010, 2'b10, 1'b0, 1'b1, 1'b0);
        #1;
        check("press_level", 4'(level), 4'b0001);
        check("press_latch", 4'(press), 4'b0001);
        check("press_rd_p1", bus.rd_data, 4'b0101);
        cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check("slides_rd_p0", bus.rd_data, 4'b1010);

        // Release: level drops, latch stays.
        for (int k = 0; k < 7; k++) cycle(4'b1010, 2'b11, 1'b0, 1'b0, 1'b0);
        #1;
        check("release_level", 4'(level), 4'b0000);
        check("release_press", 4'(press), 4'b0001);

        // Clear-on-read: latch still visible in the read cycle.
        cycle(4'b1010, 2'b11, 1'b1, 1'b1, 1'b0);
        #1;
        check("clear_rd_cycle", bus.rd_data, 4'b0100);
        cycle(4'b1010, 2'b11, 1'b0, 1'b0, 1'b0);
        #1;
        check("clear_after", 4'(press), 4'b0000);

        // Set/clear collision: read ends on the edge where level rises.
        cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        cycle(4'b1010, 2'b10, 1'b1, 1'b1, 1'b0);
        cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check("collide_press", 4'(press), 4'b0001);
        check("collide_level", 4'(level), 4'b0001);

        // Port-0 read must not clear the latch.
        cycle(4'b1010, 2'b10, 1'b1, 1'b0, 1'b0);
        cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check("p0_read_keeps", 4'(press), 4'b0001);

        // Bounce on button 1: low for 3 cycles, then released.
        for (int k = 0; k < 3; k++) cycle(4'b1010, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) cycle(4'b1010, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        check("bounce_level1", 4'(level[1]), 4'b0000);
        check("bounce_press1", 4'(press[1]), 4'b0000);

        // Randomized phase with occasional mid-run resets.
        sl = 4'b1010;
        bt = 2'b10;
        r  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 5 == 0) sl = 4'($urandom);
            for (int i = 0; i < 2; i++) begin
                if ($urandom % 6 == 0) bt[i] = ~bt[i];
            end
            r = r ? 1'($urandom % 2) : 1'($urandom % 300 == 0);
            cycle(sl, bt, 1'($urandom % 3 == 0), 1'($urandom % 2), r);
        end
        cycle(sl, bt, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 4'(sb_q.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
